// File: rtl/handshake_fifo_buffer_194.sv
// ---------------------------------------------------------------------------
// handshake_fifo_buffer_194
//
// Elastic FIFO buffer placed downstream of constant/operator stages. It
// captures every accepted (ins, ins_valid) token and replays the tokens in
// order on (outs, outs_valid). The buffer has one cycle of latency. The valid
// and ready paths are registered, so outs_valid and ins_ready come only from
// internal state. With SLOTS >= 2 the buffer passes one token per cycle.
//
// Parameters:
//   DATA_WIDTH - token width in bits (>= 1)
//   SLOTS      - buffer depth in tokens (>= 1, any value)
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous, active-high reset
//   ins        in   input token data
//   ins_valid  in   producer offers a token
//   ins_ready  out  buffer can accept a token (count != SLOTS)
//   outs       out  head token data (don't-care while outs_valid = 0)
//   outs_valid out  head token available (count != 0)
//   outs_ready in   consumer accepts the head token
// ---------------------------------------------------------------------------
module handshake_fifo_buffer_194 #(
    parameter int DATA_WIDTH = 32,
    parameter int SLOTS      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    localparam int PTR_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int CNT_W = $clog2(SLOTS + 1);

    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(SLOTS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SLOTS);

    logic [DATA_WIDTH-1:0] mem [SLOTS];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_next;

    logic push;
    logic pop;

    // Both handshake flags depend only on count. This keeps the ready path
    // from combinationally following outs_ready. When the buffer is full, a
    // pop frees the slot and ins_ready rises on the following cycle.
    assign ins_ready  = (count != FULL_CNT);
    assign outs_valid = (count != '0);

    assign push = ins_valid & ins_ready;
    assign pop  = outs_valid & outs_ready;

    // NOTE: every variable in an always_comb gets a default first, so no
    // path through the block leaves it unassigned and infers a latch.
    always_comb begin
        count_next = count;
        unique case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the values from before the edge, whatever the statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= (tail == LAST_IDX) ? '0 : tail + 1'b1;
            end
            if (pop) begin
                head <= (head == LAST_IDX) ? '0 : head + 1'b1;
            end
            count <= count_next;
        end
    end

    // NOTE: the storage array is not reset. Reset clears only the pointers
    // and count, so stale contents are never visible as valid tokens.
    // A one-slot buffer always uses entry 0. This avoids a pointer-indexed
    // select into a single-entry array.
    if (SLOTS == 1) begin : g_single
        always_ff @(posedge clk) begin
            if (push) begin
                mem[0] <= ins;
            end
        end
        assign outs = mem[0];
    end else begin : g_multi
        always_ff @(posedge clk) begin
            if (push) begin
                mem[tail] <= ins;
            end
        end
        assign outs = mem[head];
    end

endmodule

// File: tb/tb_handshake_fifo_buffer_194.sv
module tb_handshake_fifo_buffer_194;

    logic        clk;
    logic        rst;
    logic [31:0] ins;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] outs;
    logic        outs_valid;
    logic        outs_ready;

    // Instance for the single-slot variant.
    logic [7:0]  s_ins;
    logic        s_ins_valid;
    logic        s_ins_ready;
    logic [7:0]  s_outs;
    logic        s_outs_valid;
    logic        s_outs_ready;

    int errors = 0;
    int checks = 0;

    handshake_fifo_buffer_194 #(.DATA_WIDTH(32), .SLOTS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .ins        (ins),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .outs       (outs),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready)
    );

    handshake_fifo_buffer_194 #(.DATA_WIDTH(8), .SLOTS(1)) dut_one (
        .clk        (clk),
        .rst        (rst),
        .ins        (s_ins),
        .ins_valid  (s_ins_valid),
        .ins_ready  (s_ins_ready),
        .outs       (s_outs),
        .outs_valid (s_outs_valid),
        .outs_ready (s_outs_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are read 1 time unit after the rising edge. Inputs are driven
    // at that same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ins = 32'h25; ins_valid = 1'b1; outs_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (outs_valid !== 1'b0) begin errors++; $display("FAIL reset_outs_valid c%0d: got %b want 0", c, outs_valid); end
            checks++; if (ins_ready !== 1'b1) begin errors++; $display("FAIL reset_ins_ready c%0d: got %b want 1", c, ins_ready); end
        end
        ins_valid = 1'b0;
        rst = 1'b0;
        step();
        step();
        checks++; if (outs_valid !== 1'b0) begin errors++; $display("FAIL reset_no_token: outs_valid got %b want 0", outs_valid); end
    endtask

    task automatic test_stream();
        ins = 32'h25; ins_valid = 1'b1; outs_ready = 1'b1;
        checks++; if (outs_valid !== 1'b0) begin errors++; $display("FAIL stream_no_bypass: outs_valid got %b want 0", outs_valid); end
        for (int c = 0; c < 6; c++) begin
            step();
            checks++; if (outs_valid !== 1'b1 || outs !== 32'h25) begin errors++; $display("FAIL stream_out c%0d: got v=%b d=%h want v=1 d=25", c, outs_valid, outs); end
            checks++; if (ins_ready !== 1'b1) begin errors++; $display("FAIL stream_ready c%0d: got %b want 1", c, ins_ready); end
        end
        ins_valid = 1'b0;
        step();
        checks++; if (outs_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: outs_valid got %b want 0", outs_valid); end
    endtask

    task automatic test_fill_full();
        logic [31:0] exp_q [5];
        int k;
        bit accepted;
        exp_q = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
        outs_ready = 1'b0; ins_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            ins = 32'(i);
            step();
        end
        checks++; if (ins_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", ins_ready); end
        checks++; if (outs_valid !== 1'b1 || outs !== 32'h1) begin errors++; $display("FAIL full_head: got v=%b d=%h want v=1 d=1", outs_valid, outs); end
        ins = 32'h5;
        step();
        checks++; if (ins_ready !== 1'b0 || outs !== 32'h1) begin errors++; $display("FAIL full_stall: got rdy=%b d=%h want rdy=0 d=1", ins_ready, outs); end
        outs_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 12 && k < 5; c++) begin
            if (c == 0) begin
                checks++; if (ins_ready !== 1'b0) begin errors++; $display("FAIL full_ready_pop_cycle: got %b want 0", ins_ready); end
            end
            if (c == 1) begin
                checks++; if (ins_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop: got %b want 1", ins_ready); end
            end
            if (outs_valid) begin
                checks++; if (outs !== exp_q[k]) begin errors++; $display("FAIL full_order #%0d: got %h want %h", k, outs, exp_q[k]); end
                k++;
            end
            accepted = ins_valid && ins_ready;
            step();
            if (accepted) ins_valid = 1'b0;
        end
        checks++; if (k != 5) begin errors++; $display("FAIL full_count: got %0d tokens want 5", k); end
        step();
        checks++; if (outs_valid !== 1'b0) begin errors++; $display("FAIL full_drain: outs_valid got %b want 0", outs_valid); end
    endtask

    task automatic test_wrap();
        int s = 0;
        int r = 0;
        bit do_push;
        for (int c = 0; c < 80 && r < 10; c++) begin
            outs_ready = (c % 2 == 0);
            ins_valid  = (s < 10);
            ins        = 32'(s);
            if (outs_valid && outs_ready) begin
                checks++; if (outs !== 32'(r)) begin errors++; $display("FAIL wrap_order #%0d: got %h want %h", r, outs, r); end
                r++;
            end
            do_push = ins_valid && ins_ready;
            step();
            if (do_push) s++;
        end
        ins_valid = 1'b0;
        checks++; if (r != 10) begin errors++; $display("FAIL wrap_count: got %0d tokens want 10", r); end
        checks++; if (outs_valid !== 1'b0) begin errors++; $display("FAIL wrap_extra: outs_valid got %b want 0", outs_valid); end
    endtask

    task automatic test_simultaneous();
        outs_ready = 1'b0; ins_valid = 1'b1;
        ins = 32'hB; step();
        ins = 32'hC; step();
        ins = 32'hA; outs_ready = 1'b1;
        checks++; if (outs !== 32'hB) begin errors++; $display("FAIL simul_head: got %h want b", outs); end
        step();
        ins_valid = 1'b0;
        checks++; if (outs_valid !== 1'b1 || outs !== 32'hC) begin errors++; $display("FAIL simul_next: got v=%b d=%h want v=1 d=c", outs_valid, outs); end
        step();
        checks++; if (outs_valid !== 1'b1 || outs !== 32'hA) begin errors++; $display("FAIL simul_new: got v=%b d=%h want v=1 d=a", outs_valid, outs); end
        step();
        checks++; if (outs_valid !== 1'b0) begin errors++; $display("FAIL simul_count: outs_valid got %b want 0", outs_valid); end
    endtask

    task automatic test_reset_mid();
        outs_ready = 1'b0; ins_valid = 1'b1;
        ins = 32'h11; step();
        ins = 32'h12; step();
        ins = 32'h13; step();
        ins_valid = 1'b0;
        checks++; if (outs_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre: outs_valid got %b want 1", outs_valid); end
        #2 rst = 1'b1;
        #1;
        checks++; if (outs_valid !== 1'b0) begin errors++; $display("FAIL midrst_async: outs_valid got %b want 0", outs_valid); end
        step();
        rst = 1'b0;
        ins = 32'h7; ins_valid = 1'b1;
        step();
        ins_valid = 1'b0;
        checks++; if (outs_valid !== 1'b1 || outs !== 32'h7) begin errors++; $display("FAIL midrst_first: got v=%b d=%h want v=1 d=7", outs_valid, outs); end
        outs_ready = 1'b1;
        step();
        checks++; if (outs_valid !== 1'b0) begin errors++; $display("FAIL midrst_old: outs_valid got %b want 0", outs_valid); end
        outs_ready = 1'b0;
    endtask

    task automatic test_single_slot();
        int s = 0;
        int r = 0;
        bit do_push;
        s_ins_valid = 1'b1; s_outs_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            s_ins = 8'(8'h30 + s);
            checks++; if (s_ins_ready !== (c % 2 == 0)) begin errors++; $display("FAIL one_ready c%0d: got %b want %b", c, s_ins_ready, (c % 2 == 0)); end
            checks++; if (s_outs_valid !== (c % 2 == 1)) begin errors++; $display("FAIL one_valid c%0d: got %b want %b", c, s_outs_valid, (c % 2 == 1)); end
            if (s_outs_valid) begin
                checks++; if (s_outs !== 8'(8'h30 + r)) begin errors++; $display("FAIL one_order #%0d: got %h want %h", r, s_outs, 8'h30 + r); end
                r++;
            end
            do_push = s_ins_valid && s_ins_ready;
            step();
            if (do_push) s++;
        end
        s_ins_valid = 1'b0;
        checks++; if (s != 6) begin errors++; $display("FAIL one_rate: got %0d accepted want 6", s); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        ins = '0; ins_valid = 1'b0; outs_ready = 1'b0;
        s_ins = '0; s_ins_valid = 1'b0; s_outs_ready = 1'b0;
        #1;
        test_reset();
        test_stream();
        test_fill_full();
        test_wrap();
        test_simultaneous();
        test_reset_mid();
        test_single_slot();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/handshake_fifo_buffer_194.md
Name: handshake_fifo_buffer_194

Overview:
- Elastic FIFO buffer that sits directly downstream of constant/operator stages in the dataflow netlist.
- Captures each (outs, outs_valid) token a producer such as a handshake constant emits, and replays the tokens in order to the consumer.
- Cuts the combinational valid path and the ready path between producer and consumer; one-cycle latency and full throughput when SLOTS >= 2.

Parameters:
DATA_WIDTH, 32, token data width in bits (>= 1)
SLOTS, 4, buffer depth in tokens (>= 1; power of two not required)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
ins  input  DATA_WIDTH  input token data
ins_valid  input  1  producer offers a token
ins_ready  output  1  buffer can accept a token
outs  output  DATA_WIDTH  head token data
outs_valid  output  1  head token available
outs_ready  input  1  consumer accepts the head token

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- State:
  - mem[0..SLOTS-1], DATA_WIDTH each, not reset.
  - head and tail pointers, width max(1, clog2(SLOTS)).
  - count, width clog2(SLOTS+1).
- Reset:
  - While rst is high: head = tail = count = 0 immediately (asynchronous).
  - Consequently outs_valid = 0 and ins_ready = 1.
  - No transfer is recorded while rst is high.
- push = ins_valid & ins_ready. pop = outs_valid & outs_ready. Both are evaluated in the same cycle.
- ins_ready = (count != SLOTS). It depends on registered state only and never combinationally on outs_ready.
- outs_valid = (count != 0). outs = mem[head]. outs is don't-care while outs_valid = 0.
- On push: mem[tail] <= ins. tail advances, wrapping from SLOTS-1 to 0.
- On pop: head advances, wrapping from SLOTS-1 to 0.
- count update:
  - push only: count + 1.
  - pop only: count - 1.
  - push and pop together: count unchanged.
  - neither: count unchanged.
- Latency: a token pushed in cycle N is presented on outs with outs_valid = 1 in cycle N+1. There is no combinational bypass when empty.
- Empty with push and outs_ready high: no pop that cycle, because outs_valid = 0.
- Full: ins_ready = 0, so a push and pop in the same cycle cannot occur. A pop frees a slot and ins_ready rises the next cycle.
  - SLOTS = 1 therefore sustains at most one token every 2 cycles.
  - SLOTS >= 2 sustains one token per cycle in steady state.
- Stalls:
  - outs and outs_valid stay stable while outs_valid = 1 and outs_ready = 0.
  - Tokens are never dropped, duplicated or reordered.
- Reset mid-operation: all buffered tokens are discarded. The first post-reset output is the first token pushed after rst deasserts.
- ins is sampled only on push; its value when ins_valid = 0 is irrelevant.

Test Plan:
1. Reset, then hold rst high for 3 cycles with ins_valid = 1 and ins = 0x25 -> outs_valid = 0 and ins_ready = 1 throughout; no token appears after rst drops with ins_valid = 0.
2. Stream from a constant producer: ins = 0x25 with ins_valid = 1 held, outs_ready = 1 held, SLOTS = 4 -> outs_valid rises one cycle after the first push, then outs = 0x25 every cycle; ins_ready stays 1.
3. Fill to full: push 0x1, 0x2, 0x3, 0x4 with outs_ready = 0 -> ins_ready = 0 after the 4th push and a 5th token 0x5 is not accepted; then set outs_ready = 1 -> outputs 0x1, 0x2, 0x3, 0x4 in order, and 0x5 is accepted the cycle after the first pop.
4. Wrap-around: 10 tokens 0..9 with outs_ready toggling 1,0,1,0,... -> the output sequence is exactly 0..9 with no loss or duplication, and pointers wrap past index 3.
5. Simultaneous push/pop at count = 2: push 0xA while popping -> count remains 2 and the next outputs are the older tokens, then 0xA.
6. Reset mid-stream: with 3 tokens buffered, pulse rst asynchronously, mid-cycle -> outs_valid drops immediately; after release, push 0x7 -> the next output is 0x7, with no old tokens.
7. SLOTS = 1 variant: continuous ins_valid and outs_ready -> one token accepted every 2 cycles, order preserved.
